// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use stalls and branch flushes for the IF/ID / ID/EX front end.
// Optional HAZARD_PERF_CNT_EN adds stall/flush performance counters.
module hazard_ctrl_unit #(
    parameter int unsigned REG_ADDR_W   = 5,
    parameter int unsigned STALL_CYCLES = 1,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] IFID_rs1,
    input  logic [REG_ADDR_W-1:0] IFID_rs2,
    input  logic [REG_ADDR_W-1:0] IDEX_rd,
    input  logic                  IDEX_MemRead,
    input  logic                  Branch_taken,
    output logic                  PC_Write,
    output logic                  IFID_Write,
    output logic                  Flush,
    output logic                  IDEX_Bubble,
    output logic [1:0]            hz_state,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);

    localparam logic [3:0] STALL_RELOAD = 4'(STALL_CYCLES - 1);
    localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] cnt;
    logic [3:0] cnt_next;
    logic [3:0] cnt_dec;
    logic       lu;

    assign lu = IDEX_MemRead && (IDEX_rd != '0) &&
                ((IDEX_rd == IFID_rs1) || (IDEX_rd == IFID_rs2));

    // Remaining-cycle counter never wraps below zero
    assign cnt_dec = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    assign hz_state = state;

    // Mealy outputs: a hazard or branch acts in the cycle it is seen
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        PC_Write    = 1'b1;
        IFID_Write  = 1'b1;
        Flush       = 1'b0;
        IDEX_Bubble = 1'b0;
        if (reset) begin
            PC_Write    = 1'b0;
            IFID_Write  = 1'b0;
            Flush       = 1'b1;
            IDEX_Bubble = 1'b1;
            state_next  = IDLE;
            cnt_next    = 4'd0;
        end else if (Branch_taken) begin
            Flush       = 1'b1;
            IDEX_Bubble = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_next = FLUSH;
                cnt_next   = FLUSH_RELOAD;
            end else begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (lu) begin
                        PC_Write    = 1'b0;
                        IFID_Write  = 1'b0;
                        IDEX_Bubble = 1'b1;
                        if (STALL_CYCLES > 1) begin
                            state_next = STALL;
                            cnt_next   = STALL_RELOAD;
                        end
                    end
                end
                STALL: begin
                    PC_Write    = 1'b0;
                    IFID_Write  = 1'b0;
                    IDEX_Bubble = 1'b1;
                    cnt_next    = cnt_dec;
                    if (cnt <= 4'd1) state_next = IDLE;
                end
                FLUSH: begin
                    Flush       = 1'b1;
                    IDEX_Bubble = 1'b1;
                    cnt_next    = cnt_dec;
                    if (cnt <= 4'd1) state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = 4'd0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (!IFID_Write) stall_count <= stall_count + CNT_W'(1);
            if (Flush)       flush_count <= flush_count + CNT_W'(1);
        end
    end
`else
    assign stall_count = '0;
    assign flush_count = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: directed scenarios then randomized traffic vs. a cycle-budget model.
module tb_hazard_ctrl_unit;

    localparam int unsigned RW     = 5;
    localparam int unsigned STALLS = 3;
    localparam int unsigned FLUSHS = 2;
    localparam int unsigned CW     = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [RW-1:0] rs1, rs2, rd;
    logic          mem_read, br;
    logic          pc_w, ifid_w, flush, bubble;
    logic [1:0]    st;
    logic [CW-1:0] s_cnt, f_cnt;

    always #5 clk = ~clk;

    hazard_ctrl_unit #(
        .REG_ADDR_W(RW), .STALL_CYCLES(STALLS), .FLUSH_CYCLES(FLUSHS), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .IFID_rs1(rs1), .IFID_rs2(rs2), .IDEX_rd(rd),
        .IDEX_MemRead(mem_read), .Branch_taken(br),
        .PC_Write(pc_w), .IFID_Write(ifid_w), .Flush(flush), .IDEX_Bubble(bubble),
        .hz_state(st), .stall_count(s_cnt), .flush_count(f_cnt)
    );

    typedef struct {
        logic          pc, ifid, fl, bb, rst;
        logic [1:0]    st;
        logic [CW-1:0] sc, fc;
        int            cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;
    int   cyc    = 0;

    // Model: the front end owes some number of stall or flush cycles
    int            owe_stall = 0;
    int            owe_flush = 0;
    logic [CW-1:0] m_sc = '0;
    logic [CW-1:0] m_fc = '0;

    task automatic step(input logic r, input logic [RW-1:0] a, input logic [RW-1:0] b,
                        input logic [RW-1:0] d, input logic m, input logic t);
        exp_t e;
        logic hazard;
        @(posedge clk);
        #1;
        reset = r; rs1 = a; rs2 = b; rd = d; mem_read = m; br = t;
        hazard = m && (d != 0) && (d == a || d == b);
        e.cyc = cyc;
        e.rst = r;
        e.st  = (owe_flush > 0) ? 2'd2 : (owe_stall > 0) ? 2'd1 : 2'd0;
        if (r) begin
            {e.pc, e.ifid, e.fl, e.bb} = 4'b0011;
            owe_stall = 0; owe_flush = 0;
        end else if (t) begin
            {e.pc, e.ifid, e.fl, e.bb} = 4'b1111;
            owe_stall = 0; owe_flush = FLUSHS - 1;
        end else if (owe_flush > 0) begin
            {e.pc, e.ifid, e.fl, e.bb} = 4'b1111;
            owe_flush--;
        end else if (owe_stall > 0) begin
            {e.pc, e.ifid, e.fl, e.bb} = 4'b0001;
            owe_stall--;
        end else if (hazard) begin
            {e.pc, e.ifid, e.fl, e.bb} = 4'b0001;
            owe_stall = STALLS - 1;
        end else begin
            {e.pc, e.ifid, e.fl, e.bb} = 4'b1100;
        end
`ifdef HAZARD_PERF_CNT_EN
        e.sc = m_sc; e.fc = m_fc;
        if (r) begin
            m_sc = '0; m_fc = '0;
        end else begin
            if (!e.ifid) m_sc = m_sc + 1;
            if (e.fl)    m_fc = m_fc + 1;
        end
`else
        e.sc = '0; e.fc = '0;
`endif
        exp_q.push_back(e);
        cyc++;
    endtask

    task automatic chk(input string name, input int c, input logic [CW-1:0] got, input logic [CW-1:0] want);
        checks++;
        if (got === want) passed++;
        else $display("FAIL %s cycle=%0d got=%0h want=%0h", name, c, got, want);
    endtask

    // Monitor: outputs are presented every cycle; compare mid-cycle against queued expectation
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("PC_Write",    e.cyc, CW'(pc_w),   CW'(e.pc));
            chk("IFID_Write",  e.cyc, CW'(ifid_w), CW'(e.ifid));
            chk("Flush",       e.cyc, CW'(flush),  CW'(e.fl));
            chk("IDEX_Bubble", e.cyc, CW'(bubble), CW'(e.bb));
            chk("hz_state",    e.cyc, CW'(st),     CW'(e.st));
            chk("stall_count", e.cyc, s_cnt,       e.sc);
            chk("flush_count", e.cyc, f_cnt,       e.fc);
            if (!e.rst) chk("flush_vs_hold", e.cyc, CW'(flush && !ifid_w), CW'(0));
        end
    end

    initial begin
        reset = 1'b1; rs1 = '0; rs2 = '0; rd = '0; mem_read = 1'b0; br = 1'b0;
        // Reset two cycles, then idle
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 2, 3, 0, 0);
        // Load-use on rs1, held for the whole stall
        repeat (STALLS) step(0, 5, 1, 5, 1, 0);
        step(0, 1, 2, 5, 0, 0);
        // Load-use on rs2 again
        repeat (STALLS) step(0, 2, 7, 7, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        // Load into x0 never stalls
        repeat (3) step(0, 0, 0, 0, 1, 0);
        // Branch in the second stall cycle aborts the stall
        step(0, 7, 3, 7, 1, 0);
        step(0, 7, 3, 7, 1, 1);
        step(0, 1, 3, 7, 0, 0);
        step(0, 1, 3, 2, 0, 0);
        // Branch together with a load-use hazard
        step(0, 4, 4, 4, 1, 1);
        step(0, 4, 4, 4, 1, 0);
        step(0, 1, 2, 3, 0, 0);
        // Reset mid-stall and mid-flush
        step(0, 6, 0, 6, 1, 0);
        step(1, 6, 0, 6, 1, 0);
        step(0, 1, 0, 2, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        // Randomized traffic over a small register range to provoke matches
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 49) == 0),
                 RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)),
                 ($urandom_range(0, 1) == 1), ($urandom_range(0, 7) == 0));
        end
        step(0, 0, 0, 0, 0, 0);
        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL drain got=%0d want=0", exp_q.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
